// File: rtl/m_draw_layers.sv
// m_draw_layers: layered rectangle/frame compositor, 2-stage pixel pipeline.
// Define DRAW_LAYERS_FRAME_EN to build hollow-frame mode and inner half-sizes.

module m_draw_layers #(
  parameter int NUM_LAYERS = 4,
  parameter int DATA_WIDTH = 4,
  parameter int COORD_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_start,
  input  logic                   i_valid,
  input  logic [COORD_WIDTH-1:0] current_x,
  input  logic [COORD_WIDTH-1:0] current_y,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_layer,
  input  logic [2:0]             cfg_field,
  input  logic [COORD_WIDTH-1:0] cfg_data,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_hit,
  output logic [3:0]             o_layer,
  output logic                   o_pending
);
  localparam int CW = COORD_WIDTH;
  localparam int NL = NUM_LAYERS;
  localparam int DW = DATA_WIDTH;

  typedef logic [CW-1:0] crd_t;

  // Half-open span [p-h, p+h); left edge clamps at 0, right edge is CW+1 wide.
  function automatic logic in_span(crd_t p, crd_t h, crd_t c);
    logic [CW:0] lo, hi;
    lo = {1'b0, p} - {1'b0, h};
    if (lo[CW]) lo = '0;
    hi = {1'b0, p} + {1'b0, h};
    return (h != '0) && ({1'b0, c} >= lo) && ({1'b0, c} < hi);
  endfunction

  crd_t          sh_px_q  [NL];
  crd_t          sh_py_q  [NL];
  crd_t          sh_ow_q  [NL];
  crd_t          sh_oh_q  [NL];
  logic [DW-1:0] sh_col_q [NL];
  logic [1:0]    sh_ctl_q [NL];
  crd_t          act_px_q [NL];
  crd_t          act_py_q [NL];
  crd_t          act_ow_q [NL];
  crd_t          act_oh_q [NL];
  logic [DW-1:0] act_col_q[NL];
  logic [1:0]    act_ctl_q[NL];
`ifdef DRAW_LAYERS_FRAME_EN
  localparam bit FRAME = 1'b1;
  crd_t          sh_iw_q  [NL];
  crd_t          sh_ih_q  [NL];
  crd_t          act_iw_q [NL];
  crd_t          act_ih_q [NL];
`else
  localparam bit FRAME = 1'b0;
`endif

  logic field_ok, wr_en, commit;
  logic pend_q, pend_d;

  always_comb begin
`ifdef DRAW_LAYERS_FRAME_EN
    field_ok = 1'b1;
`else
    field_ok = !(cfg_field == 3'd4 || cfg_field == 3'd5);
`endif
    wr_en  = cfg_we && field_ok && (int'(cfg_layer) < NL);
    commit = i_frame_start && pend_q;
    pend_d = pend_q;
    if (commit) pend_d = 1'b0;
    if (wr_en)  pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        sh_px_q[i]  <= '0;
        sh_py_q[i]  <= '0;
        sh_ow_q[i]  <= '0;
        sh_oh_q[i]  <= '0;
        sh_col_q[i] <= '0;
        sh_ctl_q[i] <= '0;
`ifdef DRAW_LAYERS_FRAME_EN
        sh_iw_q[i]  <= '0;
        sh_ih_q[i]  <= '0;
`endif
      end
    end else if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (cfg_layer == 4'(i)) begin
          case (cfg_field)
            3'd0: sh_px_q[i]  <= cfg_data;
            3'd1: sh_py_q[i]  <= cfg_data;
            3'd2: sh_ow_q[i]  <= cfg_data;
            3'd3: sh_oh_q[i]  <= cfg_data;
`ifdef DRAW_LAYERS_FRAME_EN
            3'd4: sh_iw_q[i]  <= cfg_data;
            3'd5: sh_ih_q[i]  <= cfg_data;
`endif
            3'd6: sh_col_q[i] <= cfg_data[DW-1:0];
            3'd7: sh_ctl_q[i] <= cfg_data[1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Commit reads the pre-write shadow, so a same-cycle write stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        act_px_q[i]  <= '0;
        act_py_q[i]  <= '0;
        act_ow_q[i]  <= '0;
        act_oh_q[i]  <= '0;
        act_col_q[i] <= '0;
        act_ctl_q[i] <= '0;
`ifdef DRAW_LAYERS_FRAME_EN
        act_iw_q[i]  <= '0;
        act_ih_q[i]  <= '0;
`endif
      end
    end else if (commit) begin
      for (int i = 0; i < NL; i++) begin
        act_px_q[i]  <= sh_px_q[i];
        act_py_q[i]  <= sh_py_q[i];
        act_ow_q[i]  <= sh_ow_q[i];
        act_oh_q[i]  <= sh_oh_q[i];
        act_col_q[i] <= sh_col_q[i];
        act_ctl_q[i] <= sh_ctl_q[i];
`ifdef DRAW_LAYERS_FRAME_EN
        act_iw_q[i]  <= sh_iw_q[i];
        act_ih_q[i]  <= sh_ih_q[i];
`endif
      end
    end
  end

  logic [NL-1:0] outer_w, ring_w, hit_d;

  always_comb begin
    outer_w = '0;
    ring_w  = '0;
    hit_d   = '0;
    for (int i = 0; i < NL; i++) begin
      outer_w[i] = in_span(act_px_q[i], act_ow_q[i], current_x)
                && in_span(act_py_q[i], act_oh_q[i], current_y);
`ifdef DRAW_LAYERS_FRAME_EN
      ring_w[i] = (act_iw_q[i] < act_ow_q[i])
               && (act_ih_q[i] < act_oh_q[i])
               && !(in_span(act_px_q[i], act_iw_q[i], current_x)
                 && in_span(act_py_q[i], act_ih_q[i], current_y));
`endif
      hit_d[i] = act_ctl_q[i][0] && outer_w[i]
              && (!(FRAME && act_ctl_q[i][1]) || ring_w[i]);
    end
  end

  logic          v1_q;
  logic [NL-1:0] hit1_q;
  logic [DW-1:0] col1_q[NL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      hit1_q <= '0;
      for (int i = 0; i < NL; i++) col1_q[i] <= '0;
    end else begin
      v1_q   <= i_valid;
      hit1_q <= hit_d;
      for (int i = 0; i < NL; i++) col1_q[i] <= act_col_q[i];
    end
  end

  logic          sel_hit;
  logic [3:0]    sel_lay;
  logic [DW-1:0] sel_col;

  always_comb begin
    sel_hit = 1'b0;
    sel_lay = '0;
    sel_col = BG_COLOR;
    for (int i = NL - 1; i >= 0; i--) begin
      if (hit1_q[i]) begin
        sel_hit = 1'b1;
        sel_lay = 4'(i);
        sel_col = col1_q[i];
      end
    end
  end

  logic          vo_q, hit_q;
  logic [3:0]    lay_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vo_q   <= 1'b0;
      hit_q  <= 1'b0;
      lay_q  <= '0;
      data_q <= BG_COLOR;
    end else begin
      vo_q <= v1_q;
      if (v1_q) begin
        hit_q  <= sel_hit;
        lay_q  <= sel_lay;
        data_q <= sel_col;
      end
    end
  end

  assign o_valid   = vo_q;
  assign o_data    = data_q;
  assign o_hit     = hit_q;
  assign o_layer   = lay_q;
  assign o_pending = pend_q;

endmodule

// File: tb/tb_m_draw_layers.sv
// tb_m_draw_layers: scoreboard bench with a geometric reference model.
// Directed test-plan cases followed by randomized config/pixel traffic.

module tb_m_draw_layers;
`ifdef DRAW_LAYERS_FRAME_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif
  localparam int NL = 4;
  localparam int BG = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [10:0] current_x = '0;
  logic [10:0] current_y = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_layer = '0;
  logic [2:0]  cfg_field = '0;
  logic [10:0] cfg_data = '0;
  logic        o_valid;
  logic [3:0]  o_data;
  logic        o_hit;
  logic [3:0]  o_layer;
  logic        o_pending;

  m_draw_layers dut (
    .clk(clk), .rst_n(rst_n),
    .i_frame_start(i_frame_start), .i_valid(i_valid),
    .current_x(current_x), .current_y(current_y),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_data(cfg_data),
    .o_valid(o_valid), .o_data(o_data), .o_hit(o_hit),
    .o_layer(o_layer), .o_pending(o_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int hit;
    int layer;
    int data;
  } exp_t;
  exp_t sb[$];

  // Fields: 0 px,1 py,2 ow,3 oh,4 iw,5 ih,6 color,7 ctrl
  int m_sh[NL][8];
  int m_act[NL][8];
  bit m_pend;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_box(int p, int h, int c);
    int lo;
    lo = p - h;
    if (lo < 0) lo = 0;
    return h > 0 && c >= lo && c < p + h;
  endfunction

  function automatic void model_pix(int x, int y, output exp_t e);
    e.hit = 0; e.layer = 0; e.data = BG; e.cyc = 0;
    for (int l = 0; l < NL; l++) begin
      bit h;
      int ctl;
      ctl = m_act[l][7];
      h = (ctl & 1) && in_box(m_act[l][0], m_act[l][2], x)
                    && in_box(m_act[l][1], m_act[l][3], y);
      if (FEN && (ctl & 2)) begin
        if (m_act[l][4] >= m_act[l][2] || m_act[l][5] >= m_act[l][3])
          h = 0;
        else if (in_box(m_act[l][0], m_act[l][4], x)
              && in_box(m_act[l][1], m_act[l][5], y))
          h = 0;
      end
      if (h && !e.hit) begin
        e.hit = 1; e.layer = l; e.data = m_act[l][6];
      end
    end
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++)
      for (int f = 0; f < 8; f++) begin
        m_sh[l][f] = 0;
        m_act[l][f] = 0;
      end
    m_pend = 0;
  endfunction

  // One clock cycle of stimulus; called at posedge+1.
  task automatic drive(input bit v, input int x, input int y, input bit fs,
                       input bit we, input int ly, input int fld, input int dat);
    exp_t e;
    i_valid = v; current_x = 11'(x); current_y = 11'(y);
    i_frame_start = fs; cfg_we = we;
    cfg_layer = 4'(ly); cfg_field = 3'(fld); cfg_data = 11'(dat);
    if (v) begin
      model_pix(x, y, e);
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    if (fs && m_pend) begin
      m_act = m_sh;
      m_pend = 0;
    end
    if (we && ly < NL && (FEN || (fld != 4 && fld != 5))) begin
      m_sh[ly][fld] = (fld == 6) ? (dat & 15) : (fld == 7) ? (dat & 3) : (dat & 2047);
      m_pend = 1;
    end
    #1;
    chk("pending", o_pending, m_pend);
  endtask

  task automatic idle(); drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic pix(input int x, input int y); drive(1, x, y, 0, 0, 0, 0, 0); endtask
  task automatic cfg(input int ly, input int f, input int d); drive(0, 0, 0, 0, 1, ly, f, d); endtask
  task automatic commit(); drive(0, 0, 0, 1, 0, 0, 0, 0); endtask

  task automatic set_layer(input int ly, input int px, input int py, input int ow,
                           input int oh, input int iw, input int ih, input int col,
                           input int ctl);
    cfg(ly, 0, px); cfg(ly, 1, py); cfg(ly, 2, ow); cfg(ly, 3, oh);
    if (FEN) begin
      cfg(ly, 4, iw); cfg(ly, 5, ih);
    end
    cfg(ly, 6, col); cfg(ly, 7, ctl);
  endtask

  task automatic drain();
    repeat (4) idle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("o_hit", o_hit, e.hit);
          chk("o_layer", o_layer, e.layer);
          chk("o_data", o_data, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_data", o_data, BG);
    chk("rst_o_hit", o_hit, 0);
    chk("rst_o_layer", o_layer, 0);
    chk("rst_o_pending", o_pending, 0);
    rst_n = 1'b1;

    pix(0, 0);
    drain();

    set_layer(1, 400, 300, 32, 32, 0, 0, 4'b1110, 2'b01);
    commit();
    pix(368, 268); pix(432, 300); pix(367, 300); pix(431, 331);
    drain();

    // Mid-frame write: old geometry persists until commit.
    cfg(1, 0, 500);
    pix(400, 300); pix(480, 300);
    drive(1, 380, 300, 1, 1, 1, 1, 310);
    pix(480, 300); pix(400, 300);
    commit();
    pix(480, 330); pix(480, 290);
    drain();

    cfg(1, 7, 0);
    if (FEN) begin
      set_layer(0, 400, 300, 100, 50, 80, 40, 4'b1001, 2'b11);
      commit();
      pix(400, 300); pix(305, 300); pix(400, 255); pix(499, 349); pix(500, 300);
      drain();
    end

    set_layer(0, 200, 200, 10, 10, 1, 1, 3, 2'b01);
    set_layer(2, 200, 200, 10, 10, 1, 1, 5, 2'b01);
    commit();
    pix(200, 200); pix(195, 205);
    cfg(0, 7, 0);
    commit();
    pix(200, 200); pix(210, 200);
    drain();

    cfg(2, 7, 0);
    set_layer(3, 10, 10, 20, 20, 1, 1, 7, 2'b01);
    commit();
    pix(0, 0); pix(29, 29); pix(30, 0); pix(2047, 2047);
    drain();

    cfg(3, 0, 50);
    pix(5, 5); pix(6, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", o_valid, 0);
    chk("midrst_o_data", o_data, BG);
    chk("midrst_o_hit", o_hit, 0);
    chk("midrst_o_layer", o_layer, 0);
    chk("midrst_o_pending", o_pending, 0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pix(0, 0); pix(10, 10);
    drain();

    for (int n = 0; n < 600; n++) begin
      int fld, dat;
      fld = $urandom_range(0, 7);
      if (!FEN && (fld == 4 || fld == 5)) fld = 7;
      case (fld)
        0, 1: dat = $urandom_range(0, 1100);
        2, 3: dat = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(20, 300);
        4, 5: dat = $urandom_range(1, 19);
        6:    dat = $urandom_range(0, 2047);
        default: dat = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1100), $urandom_range(0, 1100),
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, NL - 1), fld, dat);
    end
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_draw_layers.md
# m_draw_layers

Multi-layer rectangle/frame compositor for the VGA pixel path. Holds `NUM_LAYERS` independently configurable shapes, each either a filled rectangle or a hollow frame. Tests every layer against the current scan coordinate in a 2-stage pipeline and emits the colour of the highest-priority hit, or a background colour. Shape updates are double-buffered and committed only at a frame boundary, so a shape never tears mid-frame.

## Interface
- `NUM_LAYERS`, 4, number of shape layers (1–16); layer 0 has the highest priority.
- `DATA_WIDTH`, 4, colour width.
- `COORD_WIDTH`, 11, coordinate and half-size width.
- `BG_COLOR`, 4'b0000, colour output when no layer hits.

Ports:
- `clk`  in  1  pixel clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_frame_start`  in  1  one-cycle pulse at the start of the frame; commits pending shadow config.
- `i_valid`  in  1  `current_x`/`current_y` are valid this cycle.
- `current_x`, `current_y`  in  COORD_WIDTH each  scan coordinate.
- `cfg_we`  in  1  write strobe for shadow config.
- `cfg_layer`  in  4  target layer; values ≥ `NUM_LAYERS` are ignored.
- `cfg_field`  in  3  field select: 0 pos_x, 1 pos_y, 2 otr_hf_wth, 3 otr_hf_hgt, 4 inr_hf_wth, 5 inr_hf_hgt, 6 color, 7 ctrl ({mode,enable} in bits [1:0]).
- `cfg_data`  in  COORD_WIDTH  write data; upper bits are truncated for the color and ctrl fields.
- `o_valid`  out  1  output pixel valid.
- `o_data`  out  DATA_WIDTH  composited colour.
- `o_hit`  out  1  some layer hit.
- `o_layer`  out  4  index of the winning layer (0 when there is no hit).
- `o_pending`  out  1  shadow config is waiting for commit.

## Operation
- Each layer has a shadow register set and an active register set. `cfg_we` writes only the shadow set and sets `pending`.
- On `i_frame_start` with `pending`=1:
  - all shadow sets are copied to the active sets in a single cycle;
  - `pending` clears.
- If `cfg_we` and `i_frame_start` occur in the same cycle:
  - the commit copies the shadow contents from before the write;
  - the write lands in the shadow set;
  - `pending` stays 1.
- Geometry:
  - `pos` is the shape centre.
  - Outer box: `pos_x-otr_hf_wth <= x < pos_x+otr_hf_wth`, and the same rule in y.
  - Arithmetic is COORD_WIDTH+1 bits. A negative left/top edge clamps to 0. The right/bottom edge does not wrap.
  - Fill mode (mode=0): hit = inside the outer box.
  - Frame mode (mode=1): hit = inside the outer box and not inside the inner box. The inner box is defined the same way with `inr_hf_*`.
  - An inner half-size ≥ the outer half-size gives no hit.
  - A half-size of 0 gives no hit.
- A disabled layer (enable=0) never hits.
- Priority: the lowest-index hitting layer wins.
- Reset clears all shadow and active registers, so every layer is disabled with zero geometry, and clears `pending`.

## Timing
- Stage 1 registers the per-layer hit vector, with colours and valid carried alongside.
- Stage 2 registers the priority-select result.
- Latency from `i_valid`/coordinate to `o_valid`/`o_data` is exactly 2 cycles. Throughput is one pixel per cycle with no stalls.
- `o_data`/`o_hit`/`o_layer` are updated only when the stage-2 input is valid; otherwise they hold their value. `o_valid` follows `i_valid` delayed by 2 cycles.
- A commit takes effect for coordinates presented in the cycle after `i_frame_start`. Pixels already in flight use the old config.
- Reset values:
  - `o_valid`=0, `o_hit`=0, `o_layer`=0, `o_pending`=0.
  - `o_data`=`BG_COLOR`.
  - Pipeline valids are cleared.
- Reset mid-frame clears everything asynchronously. The first valid output after release appears 2 cycles after the first `i_valid`.

## Configuration
- `DRAW_LAYERS_FRAME_EN` defined:
  - frame mode and the inner-size registers exist;
  - `cfg_field` 4/5 write the inner half-sizes.
- Not defined:
  - the inner registers are not built;
  - `cfg_field` 4/5 writes are ignored;
  - the mode bit is stored but ignored, so every layer is a filled rectangle.

## Test plan
- Reset, then drive `i_valid` with coordinate (0,0) -> `o_valid`=1 two cycles later, `o_data`=`BG_COLOR`, `o_hit`=0, `o_pending`=0.
- Configure layer 1 with pos (400,300), half-size 32×32, color 4'b1110, fill mode, enabled; pulse `i_frame_start`:
  - pixel (368,268) -> hit, `o_layer`=1;
  - pixel (432,300) -> no hit;
  - pixel (367,300) -> no hit.
- With `DRAW_LAYERS_FRAME_EN`: layer 0 in frame mode at (400,300), outer 100×50, inner 80×40, color 4'b1001:
  - (400,300) -> background;
  - (305,300) -> 4'b1001.
- Overlap layers 0 and 2 at the same centre -> `o_layer`=0 with layer 0's colour. Disable layer 0 and commit -> `o_layer`=2.
- Write layer 1 pos_x mid-frame -> old geometry persists and `o_pending`=1 until `i_frame_start`. Write on the same cycle as `i_frame_start` -> `o_pending` stays 1.
- Layer at pos (10,10), half-size 20 -> hit at (0,0), confirming the edge clamps rather than wraps. Assert `rst_n` low mid-stream -> all outputs at their reset values immediately.
